// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared encodings for the RV32 pipeline hazard/forwarding controller
package rv_pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Sequencing counter width; covers MC_LAT up to 32 and LOAD_LAT up to 7.
  localparam int SEQ_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MC_BUSY  = 2'd2
  } haz_state_e;

endpackage

// File: rtl/rv_fwd_sel.sv
// rtl/rv_fwd_sel.sv - ALU operand forward select for one EX source register
module rv_fwd_sel
  import rv_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_RegWEn,
  input  logic            mem_is_load,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_RegWEn,
  output logic [1:0]      sel
);

  // x0 is never forwarded; the younger MEM result shadows WB on equal rd.
  always_comb begin
    sel = FWD_REG;
    if (rs != '0) begin
      if (mem_RegWEn && !mem_is_load && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_RegWEn && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/rv_pipe_hazard_ctrl.sv
// rtl/rv_pipe_hazard_ctrl.sv - load-use / multi-cycle / branch hazard sequencing and forwarding
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module rv_pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [RA_W-1:0]  ex_rs1,
  input  logic [RA_W-1:0]  ex_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_RegWEn,
  input  logic             ex_is_load,
  input  logic             ex_is_mc,
  input  logic             ex_br_taken,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_RegWEn,
  input  logic             mem_is_load,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_RegWEn,
  output logic             pc_write,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_hold,
  output logic             mc_last,
  output logic [1:0]       ForwardASel,
  output logic [1:0]       ForwardBSel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [SEQ_W-1:0] CNT_ONE = SEQ_W'(1);

  haz_state_e       state;
  logic [SEQ_W-1:0] cnt;
  logic             lu_hit;
  logic             mc_start;
  logic             br_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  rv_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs(ex_rs1), .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn), .sel(fwd_a)
  );

  rv_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs(ex_rs2), .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn), .sel(fwd_b)
  );

  always_comb begin
    lu_hit = id_valid && ex_valid && ex_RegWEn && ex_is_load && (ex_rd != '0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    mc_start = ex_valid && ex_is_mc;
    // A multi-cycle op never coexists with a taken branch; if it does, the op wins.
    br_flush = ex_valid && ex_br_taken && !mc_start;
  end

  always_comb begin
    pc_write    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    mc_last     = 1'b0;
    ForwardASel = FWD_REG;
    ForwardBSel = FWD_REG;
    if (rst_n) begin
      ForwardASel = fwd_a;
      ForwardBSel = fwd_b;
      case (state)
        ST_RUN: begin
          if (mc_start) begin
            if_id_stall = 1'b1;
            ex_hold     = 1'b1;
          end else if (br_flush) begin
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu_hit) begin
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        ST_LD_STALL: begin
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        ST_MC_BUSY: begin
          if_id_stall = 1'b1;
          mc_last     = (cnt == CNT_ONE);
          ex_hold     = (cnt != CNT_ONE);
        end
        default: begin
          pc_write = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mc_start) begin
            state <= ST_MC_BUSY;
            cnt   <= SEQ_W'(MC_LAT - 1);
          end else if (!br_flush && lu_hit && (LOAD_LAT > 1)) begin
            state <= ST_LD_STALL;
            cnt   <= SEQ_W'(LOAD_LAT - 1);
          end
        end
        ST_LD_STALL, ST_MC_BUSY: begin
          if (cnt == CNT_ONE) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(ex_valid && ex_is_mc && ex_br_taken));

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if ((state == ST_RUN) && br_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_rv_pipe_hazard_ctrl.sv
// tb/tb_rv_pipe_hazard_ctrl.sv - directed and randomized check of rv_pipe_hazard_ctrl against a cycle-budget model
module tb_rv_pipe_hazard_ctrl;

  localparam int RA_W     = 5;
  localparam int LOAD_LAT = 3;
  localparam int MC_LAT   = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            id_valid, id_use_rs1, id_use_rs2;
  logic [RA_W-1:0] id_rs1, id_rs2;
  logic            ex_valid, ex_RegWEn, ex_is_load, ex_is_mc, ex_br_taken;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [RA_W-1:0] mem_rd, wb_rd;
  logic            mem_RegWEn, mem_is_load, wb_RegWEn;
  logic            pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_hold, mc_last;
  logic [1:0]      ForwardASel, ForwardBSel;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  rv_pipe_hazard_ctrl #(.RA_W(RA_W), .LOAD_LAT(LOAD_LAT), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_RegWEn(ex_RegWEn), .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc), .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn),
    .pc_write(pc_write), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_hold(ex_hold), .mc_last(mc_last),
    .ForwardASel(ForwardASel), .ForwardBSel(ForwardBSel),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: remaining cycles still owed to an in-flight stall, plus expected counters.
  int ld_left = 0;
  int mc_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", tag, cyc, got, want);
    end
  endtask

  function automatic int fwd_ref(input logic [RA_W-1:0] rs);
    if (rs == 0) return 0;
    if (mem_RegWEn && !mem_is_load && mem_rd == rs) return 1;
    if (wb_RegWEn && wb_rd == rs) return 2;
    return 0;
  endfunction

  function automatic bit load_use();
    if (!(id_valid && ex_valid && ex_RegWEn && ex_is_load) || ex_rd == 0) return 0;
    return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_RegWEn = 0; ex_is_load = 0; ex_is_mc = 0; ex_br_taken = 0;
    mem_rd = 0; mem_RegWEn = 0; mem_is_load = 0; wb_rd = 0; wb_RegWEn = 0;
  endtask

  // Inputs are applied at posedge+1; outputs are checked at posedge+2, then the model advances.
  task automatic step();
    int e_pc, e_st, e_if, e_ie, e_hold, e_last, fa, fb;
    bit fl;
    #1;
    e_pc = 0; e_st = 0; e_if = 0; e_ie = 0; e_hold = 0; e_last = 0; fa = 0; fb = 0; fl = 0;
    if (rst_n) begin
      fa = fwd_ref(ex_rs1);
      fb = fwd_ref(ex_rs2);
      if (mc_left > 0) begin
        e_st = 1; e_last = (mc_left == 1); e_hold = !e_last; mc_left--;
      end else if (ld_left > 0) begin
        e_st = 1; e_ie = 1; ld_left--;
      end else if (ex_valid && ex_is_mc) begin
        e_st = 1; e_hold = 1; mc_left = MC_LAT - 1;
      end else if (ex_valid && ex_br_taken) begin
        e_pc = 1; e_if = 1; e_ie = 1; fl = 1;
      end else if (load_use()) begin
        e_st = 1; e_ie = 1; ld_left = LOAD_LAT - 1;
      end else begin
        e_pc = 1;
      end
    end
    chk("pc_write", pc_write, e_pc);
    chk("if_id_stall", if_id_stall, e_st);
    chk("if_id_flush", if_id_flush, e_if);
    chk("id_ex_flush", id_ex_flush, e_ie);
    chk("ex_hold", ex_hold, e_hold);
    chk("mc_last", mc_last, e_last);
    chk("fwd_a", ForwardASel, fa);
    chk("fwd_b", ForwardBSel, fb);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
`else
    chk("stall_cycles", stall_cycles, 0);
    chk("flush_count", flush_count, 0);
`endif
    if (!rst_n) begin
      ld_left = 0; mc_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_pc == 0 && m_stall < CNT_MAX) m_stall++;
      if (fl && m_flush < CNT_MAX) m_flush++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1;
    step();

    // MEM beats WB on equal rd; x0 never forwarded
    idle();
    ex_valid = 1; ex_rs1 = 5; ex_rs2 = 0;
    mem_rd = 5; mem_RegWEn = 1; wb_rd = 5; wb_RegWEn = 1;
    step();
    chk("t1_fwd_a_mem", ForwardASel, 2'b01);
    chk("t1_fwd_b_x0", ForwardBSel, 2'b00);

    // lw x7 in EX, ID uses x7: LOAD_LAT stall cycles
    idle();
    ex_valid = 1; ex_is_load = 1; ex_RegWEn = 1; ex_rd = 7;
    id_valid = 1; id_rs1 = 7; id_use_rs1 = 1;
    step();
    ex_valid = 0; ex_is_load = 0;
    step();
    step();
    step();
    chk("t2_resume", pc_write, 1);

    // multi-cycle op: 3 hold cycles then mc_last
    idle();
    ex_valid = 1; ex_is_mc = 1; ex_RegWEn = 1; ex_rd = 9;
    for (int i = 0; i < MC_LAT; i++) step();
    idle();
    step();

    // taken branch overrides load-use; no stall afterwards
    idle();
    ex_valid = 1; ex_br_taken = 1; ex_is_load = 1; ex_RegWEn = 1; ex_rd = 7;
    id_valid = 1; id_rs2 = 7; id_use_rs2 = 1;
    step();
    idle();
    id_valid = 1; id_rs2 = 7; id_use_rs2 = 1;
    step();
    chk("t4_no_ld_stall", pc_write, 1);

    // reset in the middle of a multi-cycle busy period
    idle();
    ex_valid = 1; ex_is_mc = 1;
    step();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    idle();
    step();
    chk("t5_stall_cnt_clear", stall_cycles, 0);

    // enough load-use stalls to saturate a 4-bit counter
    for (int r = 0; r < 7; r++) begin
      idle();
      ex_valid = 1; ex_is_load = 1; ex_RegWEn = 1; ex_rd = 3;
      id_valid = 1; id_rs1 = 3; id_use_rs1 = 1;
      step();
      ex_valid = 0;
      step();
      step();
    end
`ifdef HAZ_PERF_CNT_EN
    chk("t6_stall_sat", stall_cycles, CNT_MAX);
`else
    chk("t6_stall_off", stall_cycles, 0);
`endif

    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 63) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = RA_W'($urandom_range(0, 3));
      id_rs2      = RA_W'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1) == 1;
      id_use_rs2  = $urandom_range(0, 1) == 1;
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_rs1      = RA_W'($urandom_range(0, 3));
      ex_rs2      = RA_W'($urandom_range(0, 3));
      ex_rd       = RA_W'($urandom_range(0, 3));
      ex_RegWEn   = $urandom_range(0, 1) == 1;
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_is_mc    = ($urandom_range(0, 9) == 0);
      ex_br_taken = !ex_is_mc && ($urandom_range(0, 5) == 0);
      mem_rd      = RA_W'($urandom_range(0, 3));
      mem_RegWEn  = $urandom_range(0, 1) == 1;
      mem_is_load = ($urandom_range(0, 3) == 0);
      wb_rd       = RA_W'($urandom_range(0, 3));
      wb_RegWEn   = $urandom_range(0, 1) == 1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
